// File: rtl/multi_cycle_shifter.sv
// Iterative shift unit (sll/srl/sra/ror) that moves at most STEP bit positions
// per clock, with a start/done handshake.
module multi_cycle_shifter #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4,
  parameter int STEP    = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SHAMT_W-1:0] STEP_C  = SHAMT_W'(STEP);
  localparam logic [SHAMT_W:0]   WIDTH_C = (SHAMT_W+1)'(WIDTH);

  state_t             state, state_d;
  logic [WIDTH-1:0]   work, shifted;
  logic [SHAMT_W-1:0] cnt, s, cnt_rem;
  logic [SHAMT_W:0]   rot_back;
  logic [1:0]         op_q;
  logic               accept;

  // One step of the shift: s = min(STEP, cnt) positions in the latched direction.
  always_comb begin
    s        = (cnt < STEP_C) ? cnt : STEP_C;
    cnt_rem  = cnt - s;
    rot_back = WIDTH_C - {1'b0, s};
    shifted  = work;
    case (op_q)
      2'b00:   shifted = work << s;
      2'b01:   shifted = work >> s;
      2'b10:   shifted = $signed(work) >>> s;
      default: shifted = (work >> s) | (work << rot_back);
    endcase
  end

  always_comb begin
    accept  = start && (state != SHIFT);
    state_d = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE, DONE: begin
        done    = (state == DONE);
        state_d = IDLE;
        if (accept) state_d = (shamt == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        busy    = 1'b1;
        state_d = (cnt_rem == '0) ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      work   <= '0;
      cnt    <= '0;
      op_q   <= '0;
      result <= '0;
      zero   <= 1'b1;
    end else if (accept) begin
      work <= data_in;
      cnt  <= shamt;
      op_q <= op;
      if (shamt == '0) begin
        result <= data_in;
        zero   <= (data_in == '0);
      end
    end else if (state == SHIFT) begin
      work <= shifted;
      cnt  <= cnt_rem;
      if (cnt_rem == '0) begin
        result <= shifted;
        zero   <= (shifted == '0);
      end
    end
  end

endmodule

// File: tb/tb_multi_cycle_shifter.sv
// Directed and randomized bench for multi_cycle_shifter: one STEP=1 and one
// STEP=4 instance checked against an arithmetic reference model.
module tb_multi_cycle_shifter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [1:0]  op;
  logic [15:0] data_in;
  logic [3:0]  shamt;
  logic        busy_a, done_a, zero_a;
  logic        busy_b, done_b, zero_b;
  logic [15:0] result_a, result_b;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  multi_cycle_shifter #(.WIDTH(16), .SHAMT_W(4), .STEP(1)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .op(op), .data_in(data_in),
    .shamt(shamt), .busy(busy_a), .done(done_a), .result(result_a), .zero(zero_a)
  );

  multi_cycle_shifter #(.WIDTH(16), .SHAMT_W(4), .STEP(4)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .op(op), .data_in(data_in),
    .shamt(shamt), .busy(busy_b), .done(done_b), .result(result_b), .zero(zero_b)
  );

  function automatic logic [15:0] ref_shift(input logic [1:0] o, input logic [15:0] x, input int k);
    int v  = int'(x);
    int sv = (v >= 32768) ? v - 65536 : v;
    int r;
    case (o)
      2'b00:   r = v * (1 << k);
      2'b01:   r = v / (1 << k);
      2'b10:   r = sv >>> k;
      default: r = (v >> k) | (v << (16 - k));
    endcase
    return r[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int which, output logic d, output logic b,
                        output logic [15:0] r, output logic z);
    if (which == 0) begin d = done_a; b = busy_a; r = result_a; z = zero_a; end
    else            begin d = done_b; b = busy_b; r = result_b; z = zero_b; end
  endtask

  task automatic run_op(input int which, input logic [1:0] o, input logic [15:0] d,
                        input logic [3:0] sh, input string tag);
    int step     = (which == 0) ? 1 : 4;
    int exp_lat  = 1 + (int'(sh) + step - 1) / step;
    logic [15:0] exp_r = ref_shift(o, d, int'(sh));
    int edges, bcnt;
    logic dn, bs, z;
    logic [15:0] r;
    @(negedge clock);
    op = o; data_in = d; shamt = sh;
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0; start_b = 1'b0;
    edges = 1; bcnt = 0;
    sample(which, dn, bs, r, z);
    while (!dn && edges < 40) begin
      if (bs) bcnt++;
      @(posedge clock); #1;
      edges++;
      sample(which, dn, bs, r, z);
    end
    check({tag, " latency"}, edges, exp_lat);
    check({tag, " busy_cycles"}, bcnt, exp_lat - 1);
    check({tag, " busy_at_done"}, bs, 1'b0);
    check({tag, " result"}, r, exp_r);
    check({tag, " zero"}, z, exp_r == 16'h0);
    @(posedge clock); #1;
    sample(which, dn, bs, r, z);
    check({tag, " done_one_cycle"}, dn, 1'b0);
    check({tag, " result_held"}, r, exp_r);
  endtask

  initial begin
    int edges, pulses;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    op = 2'b00; data_in = 16'h0; shamt = 4'h0;
    repeat (2) @(posedge clock);
    #1;
    check("reset busy_a", busy_a, 1'b0);
    check("reset done_a", done_a, 1'b0);
    check("reset result_a", result_a, 16'h0);
    check("reset zero_a", zero_a, 1'b1);
    check("reset result_b", result_b, 16'h0);
    check("reset zero_b", zero_b, 1'b1);
    reset = 1'b0;

    run_op(0, 2'b01, 16'hF0F0, 4'd4,  "srl");
    run_op(0, 2'b10, 16'h8001, 4'd15, "sra");
    run_op(0, 2'b00, 16'h0001, 4'd15, "sll");
    run_op(0, 2'b11, 16'h1234, 4'd4,  "ror");
    run_op(0, 2'b01, 16'h00A5, 4'd0,  "shamt0");
    run_op(1, 2'b01, 16'hFFFF, 4'd7,  "step4_srl");

    // start during SHIFT is ignored; start in DONE is accepted back-to-back
    @(negedge clock);
    op = 2'b01; data_in = 16'hF0F0; shamt = 4'd4; start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    @(posedge clock); #1;
    data_in = 16'hFFFF; start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    edges = 3;
    while (!done_a && edges < 40) begin
      @(posedge clock); #1;
      edges++;
    end
    check("ignore latency", edges, 5);
    check("ignore result", result_a, 16'h0F0F);
    op = 2'b00; data_in = 16'h0000; shamt = 4'd2; start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    check("b2b busy", busy_a, 1'b1);
    check("b2b done_low", done_a, 1'b0);
    edges = 1;
    while (!done_a && edges < 40) begin
      @(posedge clock); #1;
      edges++;
    end
    check("b2b latency", edges, 3);
    check("b2b result", result_a, 16'h0000);
    check("b2b zero", zero_a, 1'b1);

    run_op(0, 2'b11, 16'h1234, 4'd4, "pre_reset");

    // reset on the 2nd SHIFT cycle abandons the operation
    @(negedge clock);
    op = 2'b00; data_in = 16'h00FF; shamt = 4'd8; start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort busy", busy_a, 1'b0);
    check("abort done", done_a, 1'b0);
    check("abort result", result_a, 16'h0000);
    check("abort zero", zero_a, 1'b1);
    pulses = 0;
    repeat (12) begin
      @(posedge clock); #1;
      if (done_a || busy_a) pulses++;
    end
    check("abort no_done", pulses, 0);
    run_op(0, 2'b01, 16'h8000, 4'd15, "post_reset_srl");

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             16'($urandom), 4'($urandom_range(0, 15)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
